// File: rtl/tft_rect_fill.sv
// rtl/tft_rect_fill.sv - clipped solid RGB565 rectangle drawer feeding a byte-level SPI TFT transmitter
module tft_rect_fill #(
   parameter int COORD_W  = 9,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   input  logic [15:0]        color,
   input  logic               tft_busy,
   output logic               tft_transmit,
   output logic               tft_dc,
   output logic [7:0]         tft_data,
   output logic               busy,
   output logic               done
);
   localparam int CW1   = COORD_W + 1;
   localparam int CNT_W = $clog2(SCREEN_W * SCREEN_H + 1);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_SKIP, S_HDR, S_PIX_HI, S_PIX_LO, S_FIN} state_t;
   typedef enum logic [1:0] {P_SEND, P_WAIT_ACK, P_WAIT_DONE} phase_t;

   state_t state, state_next;
   phase_t phase, phase_next;

   logic [COORD_W-1:0] x_r, y_r, w_r, h_r;
   logic [15:0]        color_r;
   logic [3:0]         hdr_idx;
   logic [CNT_W-1:0]   pix_cnt;

   logic [CW1-1:0]     x_end_raw, y_end_raw, x_end, y_end, span_x, span_y;
   logic [2*CW1-1:0]   area;
   logic [15:0]        xs16, xe16, ys16, ye16;
   logic               skip, in_byte, byte_strobe, byte_done, accept;
   logic               byte_dc;
   logic [7:0]         byte_data;

   // Clipping is done one bit wider than the coordinates so x+w-1 never wraps.
   assign x_end_raw = {1'b0, x_r} + {1'b0, w_r} - CW1'(1);
   assign y_end_raw = {1'b0, y_r} + {1'b0, h_r} - CW1'(1);
   assign x_end     = (x_end_raw > CW1'(SCREEN_W - 1)) ? CW1'(SCREEN_W - 1) : x_end_raw;
   assign y_end     = (y_end_raw > CW1'(SCREEN_H - 1)) ? CW1'(SCREEN_H - 1) : y_end_raw;
   assign span_x    = x_end - {1'b0, x_r} + CW1'(1);
   assign span_y    = y_end - {1'b0, y_r} + CW1'(1);
   assign area      = {{CW1{1'b0}}, span_x} * {{CW1{1'b0}}, span_y};
   assign skip      = (w_r == '0) || (h_r == '0) ||
                      ({1'b0, x_r} >= CW1'(SCREEN_W)) || ({1'b0, y_r} >= CW1'(SCREEN_H));

   assign xs16 = 16'(x_r);
   assign xe16 = 16'(x_end);
   assign ys16 = 16'(y_r);
   assign ye16 = 16'(y_end);

   assign in_byte     = (state == S_HDR) || (state == S_PIX_HI) || (state == S_PIX_LO);
   assign byte_strobe = in_byte && (phase == P_SEND) && !tft_busy;
   assign byte_done   = in_byte && (phase == P_WAIT_DONE) && !tft_busy;
   assign accept      = (state == S_IDLE) && start;

   // State register: top-level sequence plus the per-byte handshake phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         phase <= P_SEND;
      end else begin
         state <= state_next;
         phase <= phase_next;
      end
   end

   // Next-state: sequence advances only when a byte has fully left the transmitter.
   always_comb begin
      state_next = state;
      phase_next = phase;
      case (state)
         S_IDLE:   if (start) state_next = S_CALC;
         S_CALC: begin
            state_next = skip ? S_SKIP : S_HDR;
            phase_next = P_SEND;
         end
         S_SKIP:   state_next = S_IDLE;
         S_HDR:    if (byte_done) state_next = (hdr_idx == 4'd10) ? S_PIX_HI : S_HDR;
         S_PIX_HI: if (byte_done) state_next = S_PIX_LO;
         S_PIX_LO: if (byte_done) state_next = (pix_cnt == CNT_W'(1)) ? S_FIN : S_PIX_HI;
         S_FIN:    state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (in_byte) begin
         case (phase)
            P_SEND:      if (!tft_busy) phase_next = P_WAIT_ACK;
            P_WAIT_ACK:  if (tft_busy)  phase_next = P_WAIT_DONE;
            P_WAIT_DONE: if (!tft_busy) phase_next = P_SEND;
            default:     phase_next = P_SEND;
         endcase
      end
   end

   // Outputs: status flags and the byte that the current step would send.
   always_comb begin
      busy      = (state != S_IDLE) && (state != S_SKIP) && (state != S_FIN);
      done      = (state == S_SKIP) || (state == S_FIN);
      byte_dc   = 1'b1;
      byte_data = 8'h00;
      case (state)
         S_HDR: begin
            case (hdr_idx)
               4'd0:    begin byte_dc = 1'b0; byte_data = 8'h2A; end
               4'd1:    byte_data = xs16[15:8];
               4'd2:    byte_data = xs16[7:0];
               4'd3:    byte_data = xe16[15:8];
               4'd4:    byte_data = xe16[7:0];
               4'd5:    begin byte_dc = 1'b0; byte_data = 8'h2B; end
               4'd6:    byte_data = ys16[15:8];
               4'd7:    byte_data = ys16[7:0];
               4'd8:    byte_data = ye16[15:8];
               4'd9:    byte_data = ye16[7:0];
               4'd10:   begin byte_dc = 1'b0; byte_data = 8'h2C; end
               default: byte_data = 8'h00;
            endcase
         end
         S_PIX_HI: byte_data = color_r[15:8];
         S_PIX_LO: byte_data = color_r[7:0];
         default:  byte_data = 8'h00;
      endcase
   end

   // Datapath: request latch, header index, pixel counter and registered byte strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r          <= '0;
         y_r          <= '0;
         w_r          <= '0;
         h_r          <= '0;
         color_r      <= '0;
         hdr_idx      <= '0;
         pix_cnt      <= '0;
         tft_transmit <= 1'b0;
         tft_dc       <= 1'b0;
         tft_data     <= 8'h00;
      end else begin
         if (accept) begin
            x_r     <= x;
            y_r     <= y;
            w_r     <= w;
            h_r     <= h;
            color_r <= color;
         end
         if (state == S_CALC) begin
            hdr_idx <= '0;
            pix_cnt <= CNT_W'(area);
         end
         tft_transmit <= byte_strobe;
         if (byte_strobe) begin
            tft_dc   <= byte_dc;
            tft_data <= byte_data;
         end
         if (byte_done && (state == S_HDR))    hdr_idx <= hdr_idx + 4'd1;
         if (byte_done && (state == S_PIX_LO)) pix_cnt <= pix_cnt - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_tft_rect_fill.sv
// tb/tb_tft_rect_fill.sv - directed bench for tft_rect_fill with a K-cycle byte transmitter model
module tb_tft_rect_fill;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [8:0] x = '0, y = '0, w = '0, h = '0;
   logic [15:0] color = '0;
   logic       tft_busy = 1'b0;
   logic       tft_transmit, tft_dc;
   logic [7:0] tft_data;
   logic       busy, done;

   int checks = 0;
   int errors = 0;
   logic [8:0] cap[$];
   logic [8:0] exp_q[$];
   int bcnt = 0, hold_cnt = 0, viol = 0, done_cnt = 0;
   int K = 4;

   always #5 clk = ~clk;

   tft_rect_fill #(.COORD_W(9), .SCREEN_W(320), .SCREEN_H(240)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x(x), .y(y), .w(w), .h(h), .color(color),
      .tft_busy(tft_busy), .tft_transmit(tft_transmit), .tft_dc(tft_dc),
      .tft_data(tft_data), .busy(busy), .done(done)
   );

   // Transmitter model: busy for K cycles after each strobe, plus an optional forced hold.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
         if (tft_transmit) begin
            if (tft_busy) viol++;
            cap.push_back({tft_dc, tft_data});
            bcnt = K;
         end else if (bcnt > 0) begin
            bcnt--;
         end
         if (hold_cnt > 0) hold_cnt--;
         tft_busy = (bcnt > 0) || (hold_cnt > 0);
      end
   end

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic dc, input logic [7:0] d);
      exp_q.push_back({dc, d});
   endtask

   task automatic build_exp(input int xx, input int yy, input int ww, input int hh,
                            input logic [15:0] cc, input bit append);
      int xe, ye, n;
      if (!append) exp_q.delete();
      if (ww == 0 || hh == 0 || xx >= 320 || yy >= 240) return;
      xe = xx + ww - 1; if (xe > 319) xe = 319;
      ye = yy + hh - 1; if (ye > 239) ye = 239;
      push_exp(1'b0, 8'h2A);
      push_exp(1'b1, 8'(xx >> 8)); push_exp(1'b1, 8'(xx));
      push_exp(1'b1, 8'(xe >> 8)); push_exp(1'b1, 8'(xe));
      push_exp(1'b0, 8'h2B);
      push_exp(1'b1, 8'(yy >> 8)); push_exp(1'b1, 8'(yy));
      push_exp(1'b1, 8'(ye >> 8)); push_exp(1'b1, 8'(ye));
      push_exp(1'b0, 8'h2C);
      n = (xe - xx + 1) * (ye - yy + 1);
      repeat (n) begin
         push_exp(1'b1, cc[15:8]);
         push_exp(1'b1, cc[7:0]);
      end
   endtask

   task automatic cmp_stream(input string tag);
      int bad;
      int lim;
      bad = -1;
      lim = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
         if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
      check({tag, "_len"}, cap.size(), exp_q.size());
      check({tag, "_first_bad_idx"}, bad, -1);
   endtask

   task automatic kick(input int xx, input int yy, input int ww, input int hh, input logic [15:0] cc);
      x = 9'(xx); y = 9'(yy); w = 9'(ww); h = 9'(hh); color = cc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int lat);
      lat = 1;
      while (!done && lat < 6000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_done_seen"}, int'(done), 1);
   endtask

   initial begin
      int lat, d0, n0, t;
      logic [8:0] t1 [23];
      logic [8:0] t2 [19];
      t1 = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10C, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h115, 9'h02C,
             9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100,
             9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
      t2 = '{9'h02A, 9'h101, 9'h13E, 9'h101, 9'h13F, 9'h02B, 9'h100, 9'h1EE, 9'h100, 9'h1EF, 9'h02C,
             9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_transmit", int'(tft_transmit), 0);
      check("rst_dc", int'(tft_dc), 0);
      check("rst_data", int'(tft_data), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // basic 3x2 red rectangle
      cap.delete(); exp_q.delete();
      foreach (t1[i]) exp_q.push_back(t1[i]);
      d0 = done_cnt;
      kick(10, 20, 3, 2, 16'hF800);
      check("t1_busy_after_start", int'(busy), 1);
      wait_done("t1", lat);
      @(posedge clk);
      #1;
      cmp_stream("t1");
      check("t1_done_pulses", done_cnt - d0, 1);
      check("t1_busy_after", int'(busy), 0);

      // clipped at the bottom-right corner
      cap.delete(); exp_q.delete();
      foreach (t2[i]) exp_q.push_back(t2[i]);
      kick(318, 238, 10, 10, 16'h07E0);
      wait_done("t2", lat);
      @(posedge clk);
      #1;
      cmp_stream("t2");

      // skip: zero width, then off-screen x
      cap.delete();
      kick(5, 5, 0, 4, 16'h1111);
      wait_done("skip_w0", lat);
      check("skip_w0_latency", lat, 2);
      check("skip_w0_busy_with_done", int'(busy), 0);
      @(posedge clk);
      #1;
      kick(320, 5, 4, 4, 16'h1111);
      wait_done("skip_x320", lat);
      check("skip_x320_latency", lat, 2);
      @(posedge clk);
      #1;
      check("skip_strobes", cap.size(), 0);

      // forced transmitter hold plus an ignored second start
      cap.delete();
      build_exp(0, 0, 2, 1, 16'h1234, 1'b0);
      d0 = done_cnt;
      kick(0, 0, 2, 1, 16'h1234);
      t = 0;
      while (cap.size() < 3 && t < 2000) begin @(posedge clk); #1; t++; end
      check("hold_reach_byte3", int'(cap.size() >= 3), 1);
      hold_cnt = 20;
      kick(100, 50, 7, 7, 16'hFFFF);
      check("hold_second_start_busy", int'(busy), 1);
      wait_done("hold", lat);
      @(posedge clk);
      #1;
      cmp_stream("hold");
      check("hold_done_pulses", done_cnt - d0, 1);

      // reset in the middle of the pixel stream
      cap.delete();
      kick(0, 0, 4, 4, 16'hABCD);
      t = 0;
      while (cap.size() < 16 && t < 3000) begin @(posedge clk); #1; t++; end
      check("mid_reach_pixel5", int'(cap.size() >= 16), 1);
      rst = 1'b1;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_transmit", int'(tft_transmit), 0);
      check("mid_rst_dc", int'(tft_dc), 0);
      check("mid_rst_data", int'(tft_data), 0);
      n0 = cap.size();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      t = 0;
      while (tft_busy && t < 100) begin @(posedge clk); #1; t++; end
      repeat (5) @(posedge clk);
      #1;
      check("mid_no_bytes_after_rst", cap.size(), n0);
      check("mid_no_done", done_cnt - d0, 0);
      cap.delete();
      build_exp(5, 6, 2, 2, 16'h0F0F, 1'b0);
      kick(5, 6, 2, 2, 16'h0F0F);
      wait_done("post_rst", lat);
      @(posedge clk);
      #1;
      cmp_stream("post_rst");

      // back-to-back 1x1, start on the done cycle ignored, next cycle accepted
      cap.delete();
      build_exp(7, 8, 1, 1, 16'h5555, 1'b0);
      build_exp(9, 9, 1, 1, 16'hAAAA, 1'b1);
      d0 = done_cnt;
      kick(7, 8, 1, 1, 16'h5555);
      wait_done("b2b_1", lat);
      x = 9'd300; y = 9'd200; w = 9'd9; h = 9'd9; color = 16'hDEAD;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_fin_start_ignored", int'(busy), 0);
      kick(9, 9, 1, 1, 16'hAAAA);
      check("b2b_second_accepted", int'(busy), 1);
      wait_done("b2b_2", lat);
      @(posedge clk);
      #1;
      cmp_stream("b2b");
      check("b2b_done_pulses", done_cnt - d0, 2);

      check("no_strobe_while_busy", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
